// File: rtl/svnet_tree_acc_pkg.sv
// Shared sizing helpers for the pipelined adder tree and its group accumulator.
package svnet_tree_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int tree_depth(input int count);
        return clog2(count);
    endfunction

    function automatic int tree_latency(input int count);
        return tree_depth(count) + 1;
    endfunction

    function automatic int out_width(input int width, input int count, input int acc_bits);
        return width + clog2(count) + acc_bits;
    endfunction

    // Number of lanes still alive after `level` pairwise reductions.
    function automatic int lanes_at(input int count, input int level);
        return (count + (1 << level) - 1) >> level;
    endfunction

endpackage

// File: rtl/svnet_tree_acc_if.sv
// Beat input / group result output bundle for svnet_tree_acc.
interface svnet_tree_acc_if
    import svnet_tree_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int COUNT    = 4,
    parameter int ACC_BITS = 4
);
    localparam int OW = out_width(WIDTH, COUNT, ACC_BITS);

    logic                     i_valid;
    logic                     i_ready;
    logic                     i_last;
    logic [COUNT*WIDTH-1:0]   i_data;
    logic                     o_valid;
    logic                     o_ready;
    logic [OW-1:0]            o_data;
    logic                     o_overflow;

    modport master (
        output i_valid, i_last, i_data, o_ready,
        input  i_ready, o_valid, o_data, o_overflow
    );

    modport slave (
        input  i_valid, i_last, i_data, o_ready,
        output i_ready, o_valid, o_data, o_overflow
    );
endinterface

// File: rtl/svnet_tree_acc_level.sv
// One registered pairwise reduction level: adjacent lanes are summed one bit wider,
// an odd trailing lane passes through extended.
module svnet_tree_level
    import svnet_tree_pkg::*;
#(
    parameter int IN_W      = 8,
    parameter int IN_LANES  = 4,
    parameter int SIGNED    = 1,
    localparam int OUT_W     = IN_W + 1,
    localparam int OUT_LANES = lanes_at(IN_LANES, 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         src_valid,
    input  logic                         src_last,
    input  logic [IN_LANES*IN_W-1:0]     src_data,
    output logic                         sum_valid,
    output logic                         sum_last,
    output logic [OUT_LANES*OUT_W-1:0]   sum_data
);

    logic [OUT_LANES*OUT_W-1:0] pair_sum;

    for (genvar j = 0; j < OUT_LANES; j++) begin : g_pair
        logic [IN_W-1:0]  a;
        logic [OUT_W-1:0] ea;
        assign a  = src_data[2*j*IN_W +: IN_W];
        assign ea = {(SIGNED != 0) && a[IN_W-1], a};

        if (2*j + 1 < IN_LANES) begin : g_add
            logic [IN_W-1:0]  b;
            logic [OUT_W-1:0] eb;
            assign b  = src_data[(2*j+1)*IN_W +: IN_W];
            assign eb = {(SIGNED != 0) && b[IN_W-1], b};
            assign pair_sum[j*OUT_W +: OUT_W] = ea + eb;
        end else begin : g_pass
            assign pair_sum[j*OUT_W +: OUT_W] = ea;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_valid <= 1'b0;
            sum_last  <= 1'b0;
            sum_data  <= '0;
        end else if (en) begin
            sum_valid <= src_valid;
            sum_last  <= src_last;
            sum_data  <= pair_sum;
        end
    end

endmodule

// File: rtl/svnet_tree_acc.sv
// Pipelined lane-sum tree feeding a per-group accumulator with wrap/saturate overflow
// handling; the whole pipeline advances on one global enable.
module svnet_tree_acc
    import svnet_tree_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int COUNT    = 4,
    parameter int SIGNED   = 1,
    parameter int ACC_BITS = 4,
    parameter int SATURATE = 0
) (
    input logic             clk,
    input logic             rst,
    svnet_tree_acc_if.slave bus
);

    localparam int D   = tree_depth(COUNT);
    localparam int OW  = out_width(WIDTH, COUNT, ACC_BITS);
    localparam int SW  = WIDTH + D;
    localparam int XW  = OW + 1;
    localparam int PAD = XW - SW;

    logic          adv;
    logic          t_valid;
    logic          t_last;
    logic [SW-1:0] t_sum;

    logic          res_valid;
    logic [OW-1:0] res_data;
    logic          res_ovf;
    logic [OW-1:0] acc;
    logic          first;
    logic          sticky;

    assign adv            = !res_valid || bus.o_ready;
    assign bus.i_ready    = adv && !rst;
    assign bus.o_valid    = res_valid;
    assign bus.o_data     = res_data;
    assign bus.o_overflow = res_ovf;

    if (D == 0) begin : g_direct
        assign t_valid = bus.i_valid;
        assign t_last  = bus.i_last;
        assign t_sum   = bus.i_data;
    end else begin : g_tree
        for (genvar k = 0; k < D; k++) begin : lvl
            localparam int IL = lanes_at(COUNT, k);
            localparam int IW = WIDTH + k;
            localparam int OL = lanes_at(COUNT, k + 1);

            logic                  v_in;
            logic                  l_in;
            logic [IL*IW-1:0]      d_in;
            logic                  v_out;
            logic                  l_out;
            logic [OL*(IW+1)-1:0]  d_out;

            if (k == 0) begin : g_src
                assign v_in = bus.i_valid;
                assign l_in = bus.i_last;
                assign d_in = bus.i_data;
            end else begin : g_chain
                assign v_in = lvl[k-1].v_out;
                assign l_in = lvl[k-1].l_out;
                assign d_in = lvl[k-1].d_out;
            end

            svnet_tree_level #(
                .IN_W    (IW),
                .IN_LANES(IL),
                .SIGNED  (SIGNED)
            ) u_level (
                .clk      (clk),
                .rst      (rst),
                .en       (adv),
                .src_valid(v_in),
                .src_last (l_in),
                .src_data (d_in),
                .sum_valid(v_out),
                .sum_last (l_out),
                .sum_data (d_out)
            );
        end

        assign t_valid = lvl[D-1].v_out;
        assign t_last  = lvl[D-1].l_out;
        assign t_sum   = lvl[D-1].d_out;
    end

    // One extra bit of headroom makes any single add exact, so overflow is just a range test.
    logic [XW-1:0] sum_x;
    logic [XW-1:0] base_x;
    logic [XW-1:0] raw;
    logic          ovf;
    logic [OW-1:0] clamp;
    logic [OW-1:0] acc_next;
    logic          sticky_next;

    assign sum_x  = {{PAD{(SIGNED != 0) && t_sum[SW-1]}}, t_sum};
    assign base_x = first ? '0 : {(SIGNED != 0) && acc[OW-1], acc};
    assign raw    = base_x + sum_x;

    always_comb begin
        ovf   = 1'b0;
        clamp = '1;
        if (SIGNED != 0) begin
            ovf   = raw[OW] ^ raw[OW-1];
            clamp = raw[OW] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
        end else begin
            ovf   = raw[OW];
        end
    end

    assign acc_next    = (ovf && SATURATE != 0) ? clamp : raw[OW-1:0];
    assign sticky_next = (!first && sticky) || ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            sticky    <= 1'b0;
            first     <= 1'b1;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_ovf   <= 1'b0;
        end else if (adv) begin
            res_valid <= t_valid && t_last;
            if (t_valid) begin
                acc    <= acc_next;
                sticky <= sticky_next;
                first  <= t_last;
                if (t_last) begin
                    res_data <= acc_next;
                    res_ovf  <= sticky_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_svnet_tree_acc.sv
// Table-driven and randomized checks of svnet_tree_acc against an integer group-sum model.
module tb_svnet_tree_acc;
    import svnet_tree_pkg::*;

    localparam int OW_A = out_width(8, 4, 4);
    localparam int OW_B = out_width(4, 3, 1);
    localparam int OW_S = out_width(8, 2, 0);
    localparam int LAT_A = tree_latency(4);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    svnet_tree_acc_if #(.WIDTH(8), .COUNT(4), .ACC_BITS(4)) bus_a ();
    svnet_tree_acc_if #(.WIDTH(4), .COUNT(3), .ACC_BITS(1)) bus_b ();
    svnet_tree_acc_if #(.WIDTH(8), .COUNT(4), .ACC_BITS(4)) bus_u ();
    svnet_tree_acc_if #(.WIDTH(8), .COUNT(2), .ACC_BITS(0)) bus_s ();
    svnet_tree_acc_if #(.WIDTH(8), .COUNT(2), .ACC_BITS(0)) bus_w ();

    svnet_tree_acc #(.WIDTH(8), .COUNT(4), .SIGNED(1), .ACC_BITS(4), .SATURATE(0))
        u_a (.clk(clk), .rst(rst), .bus(bus_a));
    svnet_tree_acc #(.WIDTH(4), .COUNT(3), .SIGNED(1), .ACC_BITS(1), .SATURATE(1))
        u_b (.clk(clk), .rst(rst), .bus(bus_b));
    svnet_tree_acc #(.WIDTH(8), .COUNT(4), .SIGNED(0), .ACC_BITS(4), .SATURATE(0))
        u_u (.clk(clk), .rst(rst), .bus(bus_u));
    svnet_tree_acc #(.WIDTH(8), .COUNT(2), .SIGNED(0), .ACC_BITS(0), .SATURATE(1))
        u_s (.clk(clk), .rst(rst), .bus(bus_s));
    svnet_tree_acc #(.WIDTH(8), .COUNT(2), .SIGNED(0), .ACC_BITS(0), .SATURATE(0))
        u_w (.clk(clk), .rst(rst), .bus(bus_w));

    typedef struct { longint acc; bit first; bit sticky; } model_t;
    typedef struct { longint data; bit ovf; } res_t;
    typedef struct { int l0; int l1; int l2; int l3; bit last; int exp_data; } vec_t;

    model_t ma = '{0, 1'b1, 1'b0};
    model_t mb = '{0, 1'b1, 1'b0};
    res_t   qa[$];
    res_t   qb[$];
    int     b_results = 0;

    task automatic check_output(input string name, input logic signed [63:0] act,
                                input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint lane_sum(input logic [63:0] d, input int n, input int w, input bit sgn);
        longint s, v;
        s = 0;
        for (int i = 0; i < n; i++) begin
            v = longint'((d >> (i*w)) & ((64'd1 << w) - 1));
            if (sgn && ((v >> (w-1)) & 1) == 1) v = v - (longint'(1) <<< w);
            s = s + v;
        end
        return s;
    endfunction

    // Group semantics in plain integers: exact add, then clamp or wrap into the OW-bit range.
    function automatic model_t model_step(input model_t m, input longint s, input bit last,
                                          input int ow, input bit sgn, input bit sat);
        longint lo, hi, v;
        model_t r;
        lo = sgn ? -(longint'(1) <<< (ow-1)) : 0;
        hi = sgn ? (longint'(1) <<< (ow-1)) - 1 : (longint'(1) <<< ow) - 1;
        v = m.first ? s : m.acc + s;
        r.sticky = m.first ? 1'b0 : m.sticky;
        if (v > hi || v < lo) begin
            r.sticky = 1'b1;
            if (sat) v = (v > hi) ? hi : lo;
            else begin
                v = v & ((longint'(1) <<< ow) - 1);
                if (sgn && v > hi) v = v - (longint'(1) <<< ow);
            end
        end
        r.acc = v;
        r.first = last;
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            ma = '{0, 1'b1, 1'b0};
            mb = '{0, 1'b1, 1'b0};
            qa.delete();
            qb.delete();
        end else begin
            if (bus_a.o_valid && bus_a.o_ready) begin
                if (qa.size() == 0) check_output("a_unexpected_result", 1, 0);
                else begin
                    res_t e;
                    e = qa.pop_front();
                    check_output("a_model_data", $signed(bus_a.o_data), e.data);
                    check_output("a_model_ovf", bus_a.o_overflow, e.ovf);
                end
            end
            if (bus_a.i_valid && bus_a.i_ready) begin
                ma = model_step(ma, lane_sum(64'(bus_a.i_data), 4, 8, 1'b1), bus_a.i_last, OW_A, 1'b1, 1'b0);
                if (bus_a.i_last) qa.push_back('{ma.acc, ma.sticky});
            end
            if (bus_b.o_valid && bus_b.o_ready) begin
                b_results++;
                if (qb.size() == 0) check_output("b_unexpected_result", 1, 0);
                else begin
                    res_t e;
                    e = qb.pop_front();
                    check_output("b_model_data", $signed(bus_b.o_data), e.data);
                    check_output("b_model_ovf", bus_b.o_overflow, e.ovf);
                end
            end
            if (bus_b.i_valid && bus_b.i_ready) begin
                mb = model_step(mb, lane_sum(64'(bus_b.i_data), 3, 4, 1'b1), bus_b.i_last, OW_B, 1'b1, 1'b1);
                if (bus_b.i_last) qb.push_back('{mb.acc, mb.sticky});
            end
        end
    end

    function automatic logic [31:0] pack4(input int l0, input int l1, input int l2, input int l3);
        return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
    endfunction

    task automatic apply_stimulus(input logic [31:0] data, input bit last);
        bit ok;
        ok = 1'b0;
        bus_a.i_valid = 1'b1;
        bus_a.i_data  = data;
        bus_a.i_last  = last;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            ok = bus_a.i_ready;
            @(posedge clk);
            #1;
        end
        bus_a.i_valid = 1'b0;
        if (!ok) check_output("a_accept_timeout", 0, 1);
    endtask

    task automatic wait_result(output logic signed [63:0] data, output logic ovf, output int n);
        n = -1;
        data = -1;
        ovf = 1'b0;
        for (int c = 1; c <= 20 && n < 0; c++) begin
            @(negedge clk);
            if (bus_a.o_valid) begin
                n = c;
                data = $signed(bus_a.o_data);
                ovf = bus_a.o_overflow;
            end
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[7];
    logic signed [63:0] d;
    logic ov;
    int n;
    bit seen;
    int got_c[$];
    logic signed [63:0] got_v[$];

    initial begin
        bus_a.i_valid = 0; bus_a.i_last = 0; bus_a.i_data = '0; bus_a.o_ready = 1;
        bus_b.i_valid = 0; bus_b.i_last = 0; bus_b.i_data = '0; bus_b.o_ready = 1;
        bus_u.i_valid = 0; bus_u.i_last = 0; bus_u.i_data = '0; bus_u.o_ready = 1;
        bus_s.i_valid = 0; bus_s.i_last = 0; bus_s.i_data = '0; bus_s.o_ready = 1;
        bus_w.i_valid = 0; bus_w.i_last = 0; bus_w.i_data = '0; bus_w.o_ready = 1;

        tbl[0] = '{1, 2, 3, 4, 1'b1, 10};
        tbl[1] = '{-128, -128, -128, -128, 1'b1, -512};
        tbl[2] = '{127, 127, 127, 127, 1'b1, 508};
        tbl[3] = '{-1, 1, -1, 1, 1'b1, 0};
        tbl[4] = '{1, 1, 1, 1, 1'b0, 0};
        tbl[5] = '{2, 2, 2, 2, 1'b0, 0};
        tbl[6] = '{3, 3, 3, 3, 1'b1, 24};

        @(negedge clk);
        check_output("reset_o_valid", bus_a.o_valid, 0);
        check_output("reset_o_data", bus_a.o_data, 0);
        check_output("reset_o_overflow", bus_a.o_overflow, 0);
        check_output("reset_i_ready", bus_a.i_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_output("post_reset_i_ready", bus_a.i_ready, 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            apply_stimulus(pack4(tbl[i].l0, tbl[i].l1, tbl[i].l2, tbl[i].l3), tbl[i].last);
            if (tbl[i].last) begin
                wait_result(d, ov, n);
                check_output($sformatf("tbl%0d_data", i), d, tbl[i].exp_data);
                check_output($sformatf("tbl%0d_ovf", i), ov, 0);
                check_output($sformatf("tbl%0d_latency", i), n, LAT_A);
            end else begin
                seen = 1'b0;
                for (int c = 0; c < LAT_A; c++) begin
                    @(negedge clk);
                    seen = seen | bus_a.o_valid;
                    @(posedge clk);
                    #1;
                end
                check_output($sformatf("tbl%0d_no_valid", i), seen, 0);
            end
        end

        // 17 beats of -512 leave the 14-bit signed range and wrap modulo 2**14.
        for (int i = 0; i < 17; i++) apply_stimulus(pack4(-128, -128, -128, -128), i == 16);
        wait_result(d, ov, n);
        check_output("wrap_data", d, -8704 + (1 << OW_A));
        check_output("wrap_ovf", ov, 1);
        apply_stimulus(pack4(1, 0, 0, 0), 1'b1);
        wait_result(d, ov, n);
        check_output("after_wrap_data", d, 1);
        check_output("after_wrap_ovf_cleared", ov, 0);

        bus_a.o_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            bus_a.i_valid = 1'b1;
            bus_a.i_last  = 1'b1;
            bus_a.i_data  = pack4(n + 1, 0, 0, 0);
            @(negedge clk);
            if (bus_a.i_ready) n++;
            @(posedge clk);
            #1;
        end
        bus_a.i_valid = 1'b0;
        check_output("stall_accepted", n, 3);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_output("stall_o_valid", bus_a.o_valid, 1);
            check_output("stall_o_data", bus_a.o_data, 1);
            check_output("stall_i_ready", bus_a.i_ready, 0);
            @(posedge clk);
            #1;
        end
        bus_a.o_ready = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            wait_result(d, ov, n);
            check_output("stall_drain_data", d, j);
            check_output("stall_drain_gap", n, 1);
        end

        for (int c = 0; c < 10; c++) begin
            bus_a.i_valid = (c < 4);
            bus_a.i_last  = 1'b1;
            bus_a.i_data  = pack4(c + 1, 0, 0, 0);
            @(negedge clk);
            if (c < 4) check_output("b2b_i_ready", bus_a.i_ready, 1);
            if (bus_a.o_valid) begin
                got_c.push_back(c);
                got_v.push_back($signed(bus_a.o_data));
            end
            @(posedge clk);
            #1;
        end
        bus_a.i_valid = 1'b0;
        check_output("b2b_count", got_c.size(), 4);
        for (int j = 0; j < got_c.size() && j < 4; j++) begin
            check_output("b2b_data", got_v[j], j + 1);
            check_output("b2b_cycle", got_c[j], j + LAT_A);
        end

        apply_stimulus(pack4(5, 5, 5, 5), 1'b0);
        apply_stimulus(pack4(5, 5, 5, 5), 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_output("mid_reset_i_ready", bus_a.i_ready, 0);
        check_output("mid_reset_o_valid", bus_a.o_valid, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        apply_stimulus(pack4(1, 0, 0, 0), 1'b1);
        wait_result(d, ov, n);
        check_output("after_reset_data", d, 1);

        // Unsigned view of 0x80 lanes, and 255+255 twice into a 9-bit unsigned accumulator.
        bus_u.i_valid = 1; bus_u.i_last = 1; bus_u.i_data = 32'h8080_8080;
        bus_s.i_valid = 1; bus_s.i_last = 0; bus_s.i_data = 16'hFFFF;
        bus_w.i_valid = 1; bus_w.i_last = 0; bus_w.i_data = 16'hFFFF;
        @(posedge clk);
        #1;
        bus_u.i_valid = 0;
        bus_s.i_last = 1;
        bus_w.i_last = 1;
        @(posedge clk);
        #1;
        bus_s.i_valid = 0;
        bus_w.i_valid = 0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus_u.o_valid) check_output("unsigned_data", bus_u.o_data, 512);
            if (bus_u.o_valid) check_output("unsigned_ovf", bus_u.o_overflow, 0);
            if (bus_s.o_valid) begin
                seen = 1'b1;
                check_output("sat_data", bus_s.o_data, (1 << OW_S) - 1);
                check_output("sat_ovf", bus_s.o_overflow, 1);
            end
            if (bus_w.o_valid) check_output("wrapu_data", bus_w.o_data, 1020 % (1 << OW_S));
            if (bus_w.o_valid) check_output("wrapu_ovf", bus_w.o_overflow, 1);
            @(posedge clk);
            #1;
        end
        check_output("sat_result_seen", seen, 1);

        seen = 1'b1;
        for (int c = 0; c < 600; c++) begin
            logic v, l, r;
            int l0, l1, l2;
            if ($urandom_range(0, 9) == 0) seen = !seen;
            v = ($urandom_range(0, 9) < 7);
            l = ($urandom_range(0, 5) == 0);
            r = ($urandom_range(0, 3) != 0);
            l0 = seen ? $urandom_range(0, 7) : $urandom_range(8, 15);
            l1 = seen ? $urandom_range(0, 7) : $urandom_range(8, 15);
            l2 = seen ? $urandom_range(0, 7) : $urandom_range(8, 15);
            bus_a.i_valid = v; bus_a.i_last = l; bus_a.i_data = $urandom; bus_a.o_ready = r;
            bus_b.i_valid = v; bus_b.i_last = l; bus_b.i_data = {4'(l2), 4'(l1), 4'(l0)}; bus_b.o_ready = r;
            @(posedge clk);
            #1;
        end
        bus_a.i_valid = 0; bus_a.o_ready = 1;
        bus_b.i_valid = 0; bus_b.o_ready = 1;
        repeat (10) @(posedge clk);
        #1;
        check_output("a_drain_pending", qa.size(), 0);
        check_output("b_drain_pending", qb.size(), 0);
        check_output("b_results_nonzero", b_results > 20, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
